sseg_num_decoder: RTL and testbench
===================================

// Module: sseg_num_decoder
// PURPOSE
//  Reads four active-low 7-segment patterns (H3..H0) and reconstructs the signed 8-bit value they show.
//  The patterns are in the decimal format produced by the display path: leading blanks, an optional minus
//  immediately before the most significant digit, then decimal digits.
//  The block sits on the display side of the board and self-checks display output.
//  It also accepts captured display patterns from a peer board.
//  A multi-cycle digit-serial FSM performs the conversion, with a start/valid handshake.
// PARAMETERS
//  NDIG   4   number of digit patterns scanned, H[NDIG-1] first (MSD) down to H0
//  W      8   result width, two's complement
// PORTS
//  clk       in   1        system clock, rising edge
//  n_reset   in   1        asynchronous active-low reset
//  start     in   1        request; sampled only in IDLE; ignored while busy
//  segs_in   in   7*NDIG   patterns, [7k+6:7k] = Hk, bit order g..a, active-low
//  busy      out  1        high from the cycle after an accepted start until valid is asserted
//  valid     out  1        one-cycle pulse; value/err are stable from this cycle until the next accepted start
//  err       out  1        malformed pattern sequence, or value out of range
//  value     out  W        decoded result; 0 whenever err=1
// BEHAVIOUR
//  Reset (async, n_reset=0): state=IDLE, busy=0, valid=0, err=0, value=0, acc=0, internal flags cleared.
//   - An in-flight conversion is abandoned; no valid is produced for it.
//  Legal patterns:
//   - digits 0-9: 40,79,24,30,19,12,02,78,00,18 (hex, 7-bit)
//   - blank: 7F
//   - minus: 3F
//   - any other pattern, including hex digits A-F, is illegal
//  State IDLE: on start=1, latch segs_in into a shift register, clear acc/neg/seen flags, then go to SCAN.
//   - busy=1 from the next cycle
//  State SCAN: examine one pattern per cycle, MSD first, for exactly NDIG cycles.
//   - Every pattern is examined even after an error has been flagged; latency is fixed.
//   - blank before any sign/digit: skip.
//   - blank after a sign or digit: set bad.
//   - minus when no sign and no digit yet seen: set neg.
//   - minus in any other position: set bad.
//   - digit d: acc <= acc*10 + d, set seen_digit.
//     * acc is 14 bits wide (holds 9999); no truncation is allowed.
//   - illegal pattern: set bad.
//  State DONE (1 cycle): valid=1, busy=0, then return to IDLE. Results:
//   - err=1 if any of:
//     * bad set
//     * no digit seen (all blank, or minus only)
//     * neg=1 and acc=0 ("-0" is never displayed)
//     * neg=0 and acc>2^(W-1)-1
//     * neg=1 and acc>2^(W-1)
//   - otherwise value = neg ? -acc[W-1:0] : acc[W-1:0]
//  Latency: start sampled at edge 0 -> SCAN edges 1..NDIG -> valid high in cycle NDIG+1 (5 for NDIG=4).
//  Back-to-back: start may be asserted in the valid cycle; it is accepted on the edge ending DONE->IDLE only
//   if the state is IDLE, so the minimum spacing between accepted starts is NDIG+2 cycles.
//  segs_in may change freely after the accepting edge; only the latched copy is used.
//  A start pulse arriving while busy is dropped, not queued.
// TESTING
//  T1: H3..H0 = 3F,79,24,00 ("-128"), start -> valid at cycle 5, value=8'h80, err=0; busy high cycles 1-4.
//  T2: 7F,7F,19,24 ("  42") -> value=8'd42, err=0.
//      7F,7F,7F,40 ("   0") -> value=0, err=0.
//  T3: 7F,24,12,12 (" 255") -> err=1, value=0.
//      3F,79,24,78 ("-127") -> value=8'h81, err=0.
//  T4: 3F,7F,79,40 (minus then blank) -> err=1.
//      7F,08,7F,7F (A-F pattern) -> err=1.
//      all 7F -> err=1.
//      7F,79,7F,30 (blank between digits) -> err=1.
//  T5: start again at cycles 2 and 5 of a conversion -> exactly one valid, at cycle 5.
//      The next accepted start gives its valid NDIG+2 cycles later.
//  T6: drop n_reset at cycle 3 of a conversion -> outputs 0 immediately, no valid pulse.
//      A fresh start after release converts correctly.

Source files
------------

// File: rtl/sseg_num_decoder_if.sv
// Start/result handshake between a requester and the 7-segment
// number decoder.
interface sseg_num_decoder_if #(
    parameter int NDIG = 4,
    parameter int W    = 8
);
    logic              start;
    logic [7*NDIG-1:0] segs_in;
    logic              busy;
    logic              valid;
    logic              err;
    logic [W-1:0]      value;

    modport master (
        output start, segs_in,
        input  busy, valid, err, value
    );

    modport slave (
        input  start, segs_in,
        output busy, valid, err, value
    );
endinterface

// File: rtl/sseg_num_decoder.sv
// Digit-serial decoder: turns NDIG active-low 7-segment patterns
// (MSD first) back into a signed W-bit value.
module sseg_num_decoder #(
    parameter int NDIG = 4,
    parameter int W    = 8
) (
    input  logic                clk,
    input  logic                n_reset,
    sseg_num_decoder_if.slave   bus
);
    localparam int AW = 14;
    localparam int SW = 7 * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [AW-1:0] POS_MAX = AW'((2 ** (W - 1)) - 1);
    localparam logic [AW-1:0] NEG_MAX = AW'(2 ** (W - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sh_q, sh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          neg_q, neg_d;
    logic          any_q, any_d;
    logic          dig_q, dig_d;
    logic          bad_q, bad_d;
    logic          err_q, err_d;
    logic [W-1:0]  value_q, value_d;

    logic [6:0]    pat;
    logic          is_dig;
    logic          is_blank;
    logic          is_minus;
    logic [3:0]    dig;
    logic          fail;
    logic [W-1:0]  mag;

    assign pat = sh_q[SW-1 -: 7];

    always_comb begin
        is_dig   = 1'b1;
        is_blank = 1'b0;
        is_minus = 1'b0;
        dig      = 4'd0;
        unique case (pat)
            7'h40: dig = 4'd0;
            7'h79: dig = 4'd1;
            7'h24: dig = 4'd2;
            7'h30: dig = 4'd3;
            7'h19: dig = 4'd4;
            7'h12: dig = 4'd5;
            7'h02: dig = 4'd6;
            7'h78: dig = 4'd7;
            7'h00: dig = 4'd8;
            7'h18: dig = 4'd9;
            7'h7F: begin
                is_dig   = 1'b0;
                is_blank = 1'b1;
            end
            7'h3F: begin
                is_dig   = 1'b0;
                is_minus = 1'b1;
            end
            default: is_dig = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        any_d   = any_q;
        dig_d   = dig_q;
        bad_d   = bad_q;
        err_d   = err_q;
        value_d = value_q;
        fail    = 1'b0;
        mag     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_SCAN;
                    sh_d    = bus.segs_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    neg_d   = 1'b0;
                    any_d   = 1'b0;
                    dig_d   = 1'b0;
                    bad_d   = 1'b0;
                end
            end
            S_SCAN: begin
                sh_d  = sh_q << 7;
                cnt_d = cnt_q + 1'b1;
                if (is_blank) begin
                    if (any_q) bad_d = 1'b1;
                end else if (is_minus) begin
                    if (any_q) begin
                        bad_d = 1'b1;
                    end else begin
                        neg_d = 1'b1;
                        any_d = 1'b1;
                    end
                end else if (is_dig) begin
                    acc_d = acc_q * AW'(10) + AW'(dig);
                    dig_d = 1'b1;
                    any_d = 1'b1;
                end else begin
                    bad_d = 1'b1;
                end
                // Result is formed from this cycle's updates so it is
                // already stable when valid rises.
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = S_DONE;
                    fail = bad_d || !dig_d
                        || (neg_d && acc_d == '0)
                        || (!neg_d && acc_d > POS_MAX)
                        || (neg_d && acc_d > NEG_MAX);
                    mag     = acc_d[W-1:0];
                    err_d   = fail;
                    value_d = fail ? '0 : (neg_d ? -mag : mag);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            any_q   <= 1'b0;
            dig_q   <= 1'b0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            any_q   <= any_d;
            dig_q   <= dig_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            value_q <= value_d;
        end
    end

    assign bus.busy  = (state_q == S_SCAN);
    assign bus.valid = (state_q == S_DONE);
    assign bus.err   = err_q;
    assign bus.value = value_q;
endmodule

// File: tb/tb_sseg_num_decoder.sv
// Self-checking bench for sseg_num_decoder: directed display strings,
// random strings against a string-parsing model, handshake and reset.
module tb_sseg_num_decoder;
    localparam int NDIG = 4;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    always #5 clk = ~clk;

    sseg_num_decoder_if #(.NDIG(NDIG), .W(W)) ifc ();

    sseg_num_decoder #(.NDIG(NDIG), .W(W)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (ifc.slave)
    );

    function automatic int digit_of(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (seg_tab[i] == p) return i;
        return -1;
    endfunction

    // Reads the display as text: blanks, optional '-', then digits only.
    function automatic void model(input logic [27:0] s,
                                  output logic e, output logic [7:0] v);
        int phase = 0;
        bit bad = 0;
        bit neg = 0;
        int acc = 0;
        int nd = 0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            logic [6:0] p;
            int d;
            p = s[7*k +: 7];
            d = digit_of(p);
            if (p == 7'h7F) begin
                if (phase != 0) bad = 1;
            end else if (p == 7'h3F) begin
                if (phase == 0) begin
                    neg = 1;
                    phase = 1;
                end else bad = 1;
            end else if (d >= 0) begin
                acc = acc * 10 + d;
                nd++;
                phase = 2;
            end else bad = 1;
        end
        e = bad || nd == 0 || (neg && acc == 0)
            || (!neg && acc > 127) || (neg && acc > 128);
        v = e ? 8'd0 : 8'(neg ? -acc : acc);
    endfunction

    function automatic logic [27:0] render(input int n);
        logic [27:0] r;
        int a;
        int k;
        r = {4{7'h7F}};
        a = (n < 0) ? -n : n;
        k = 0;
        do begin
            r[7*k +: 7] = seg_tab[a % 10];
            a = a / 10;
            k++;
        end while (a > 0);
        if (n < 0) r[7*k +: 7] = 7'h3F;
        return r;
    endfunction

    task automatic run_conv(input logic [27:0] s, output int lat,
                            output logic e, output logic [7:0] v,
                            output int busy_cyc);
        @(negedge clk);
        ifc.segs_in = s;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.segs_in = 28'($urandom);
        lat = 1;
        busy_cyc = 0;
        while (!ifc.valid && lat < 20) begin
            if (ifc.busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (ifc.busy) busy_cyc++;
        e = ifc.err;
        v = ifc.value;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ifc.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", ifc.busy);
        end
        n_cmp++;
        if (ifc.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", ifc.valid);
        end
        n_cmp++;
        if (ifc.err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err: got %b want 0", ifc.err);
        end
        n_cmp++;
        if (ifc.value !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_value: got %h want 00", ifc.value);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [27:0] s [18];
        logic        xe [18];
        logic [7:0]  xv [18];
        int lat, bc;
        logic e;
        logic [7:0] v;
        s = '{{7'h3F, 7'h79, 7'h24, 7'h00}, {7'h7F, 7'h7F, 7'h19, 7'h24},
              {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h24, 7'h12, 7'h12},
              {7'h3F, 7'h79, 7'h24, 7'h78}, {7'h3F, 7'h7F, 7'h79, 7'h40},
              {7'h7F, 7'h08, 7'h7F, 7'h7F}, {7'h7F, 7'h7F, 7'h7F, 7'h7F},
              {7'h7F, 7'h79, 7'h7F, 7'h30}, {7'h7F, 7'h3F, 7'h7F, 7'h7F},
              {7'h7F, 7'h3F, 7'h79, 7'h24}, {7'h7F, 7'h7F, 7'h3F, 7'h40},
              {7'h7F, 7'h79, 7'h24, 7'h78}, {7'h7F, 7'h79, 7'h24, 7'h00},
              {7'h3F, 7'h79, 7'h24, 7'h18}, {7'h79, 7'h79, 7'h79, 7'h79},
              {7'h7F, 7'h3F, 7'h3F, 7'h79}, {7'h40, 7'h40, 7'h40, 7'h79}};
        xe = '{0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0};
        xv = '{8'h80, 8'h2A, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'hF4, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h01};
        for (int i = 0; i < 18; i++) begin
            run_conv(s[i], lat, e, v, bc);
            n_cmp++;
            if (lat !== 5) begin
                n_bad++;
                $display("FAIL dir%0d_latency: got %0d want 5", i, lat);
            end
            n_cmp++;
            if (bc !== 4) begin
                n_bad++;
                $display("FAIL dir%0d_busy_cycles: got %0d want 4", i, bc);
            end
            n_cmp++;
            if (e !== xe[i]) begin
                n_bad++;
                $display("FAIL dir%0d_err: got %b want %b", i, e, xe[i]);
            end
            n_cmp++;
            if (v !== xv[i]) begin
                n_bad++;
                $display("FAIL dir%0d_value: got %h want %h", i, v, xv[i]);
            end
            @(negedge clk);
            n_cmp++;
            if (ifc.valid !== 1'b0) begin
                n_bad++;
                $display("FAIL dir%0d_valid_pulse: got %b want 0", i,
                         ifc.valid);
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, mode, n;
        logic [27:0] s;
        logic e, me;
        logic [7:0] v, mv;
        for (int it = 0; it < 60; it++) begin
            mode = int'($urandom_range(0, 2));
            n = 0;
            if (mode == 0) begin
                n = int'($urandom_range(0, 255)) - 128;
                s = render(n);
            end else if (mode == 1) begin
                n = int'($urandom_range(0, 10998)) - 999;
                s = render(n);
            end else begin
                for (int k = 0; k < NDIG; k++) begin
                    int c;
                    c = int'($urandom_range(0, 12));
                    if (c < 10) s[7*k +: 7] = seg_tab[c];
                    else if (c == 10) s[7*k +: 7] = 7'h7F;
                    else if (c == 11) s[7*k +: 7] = 7'h3F;
                    else s[7*k +: 7] = 7'($urandom);
                end
            end
            model(s, me, mv);
            run_conv(s, lat, e, v, bc);
            n_cmp++;
            if (lat !== 5) begin
                n_bad++;
                $display("FAIL rnd%0d_latency: got %0d want 5", it, lat);
            end
            n_cmp++;
            if (e !== me || v !== mv) begin
                n_bad++;
                $display("FAIL rnd%0d_result segs=%h: got err=%b val=%h want err=%b val=%h",
                         it, s, e, v, me, mv);
            end
            if (mode == 0 && n != -128 && n != 0) begin
                n_cmp++;
                if (e !== 1'b0 || v !== 8'(n)) begin
                    n_bad++;
                    $display("FAIL rnd%0d_inrange n=%0d: got err=%b val=%h want err=0 val=%h",
                             it, n, e, v, 8'(n));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int vcnt = 0;
        int first = -1;
        int second = -1;
        @(negedge clk);
        ifc.segs_in = {7'h7F, 7'h7F, 7'h19, 7'h24};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (ifc.valid) begin
                vcnt++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            ifc.start = (c == 0 || c == 2 || c == 5 || c == 6);
        end
        ifc.start = 1'b0;
        n_cmp++;
        if (first !== 5) begin
            n_bad++;
            $display("FAIL b2b_first_valid: got %0d want 5", first);
        end
        n_cmp++;
        if (second !== 11) begin
            n_bad++;
            $display("FAIL b2b_second_valid: got %0d want 11", second);
        end
        n_cmp++;
        if (vcnt !== 2) begin
            n_bad++;
            $display("FAIL b2b_valid_count: got %0d want 2", vcnt);
        end
        n_cmp++;
        if (ifc.value !== 8'h2A || ifc.err !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_result: got err=%b val=%h want err=0 val=2a",
                     ifc.err, ifc.value);
        end
    endtask

    task automatic test_reset_midflight();
        int lat, bc, vcnt;
        logic e;
        logic [7:0] v;
        run_conv({7'h3F, 7'h79, 7'h24, 7'h00}, lat, e, v, bc);
        @(negedge clk);
        ifc.segs_in = {7'h7F, 7'h7F, 7'h19, 7'h24};
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        n_reset = 1'b0;
        #1;
        n_cmp++;
        if (ifc.busy !== 1'b0 || ifc.valid !== 1'b0
            || ifc.err !== 1'b0 || ifc.value !== 8'h00) begin
            n_bad++;
            $display("FAIL midreset_outputs: got busy=%b valid=%b err=%b val=%h want all 0",
                     ifc.busy, ifc.valid, ifc.err, ifc.value);
        end
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ifc.valid) vcnt++;
        end
        n_cmp++;
        if (vcnt !== 0) begin
            n_bad++;
            $display("FAIL midreset_no_valid: got %0d pulses want 0", vcnt);
        end
        run_conv({7'h7F, 7'h7F, 7'h19, 7'h24}, lat, e, v, bc);
        n_cmp++;
        if (lat !== 5 || e !== 1'b0 || v !== 8'h2A) begin
            n_bad++;
            $display("FAIL midreset_restart: got lat=%0d err=%b val=%h want lat=5 err=0 val=2a",
                     lat, e, v);
        end
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.segs_in = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
